alu_simd_pipe_acc: RTL

ALU_SIMD_PIPE_ACC -- requirements
Module: alu_simd_pipe_acc

---
 rtl/alu_simd_pkg.sv | 14 +
 rtl/alu_simd_lane.sv | 46 ++++
 rtl/alu_simd_pipe_acc.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_simd_pkg.sv
// Shared op encodings and mode constants for the SIMD accumulating ALU.
package alu_simd_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_XOR = 2'b10,
        OP_AND = 2'b11
    } op_e;

    localparam logic MODE_CHAINED = 1'b0;
    localparam logic MODE_SIMD    = 1'b1;

endpackage

// File: rtl/alu_simd_lane.sv
// One combinational ALU lane. The carry/borrow is two bits wide because three
// operands plus an incoming carry can overflow a lane by up to two.
module alu_simd_lane
    import alu_simd_pkg::*;
#(
    parameter int LANE_W = 18
) (
    input  logic [LANE_W-1:0] x_i,
    input  logic [LANE_W-1:0] y_i,
    input  logic [LANE_W-1:0] z_i,
    input  logic [1:0]        op_i,
    input  logic [1:0]        cin_i,
    output logic [LANE_W-1:0] s_o,
    output logic [1:0]        cout_o
);
    localparam int EW = LANE_W + 2;

    logic [EW-1:0] xe, ye, ze, ce_ext, ext;

    always_comb begin
        xe     = {2'b00, x_i};
        ye     = {2'b00, y_i};
        ze     = {2'b00, z_i};
        ce_ext = {{LANE_W{1'b0}}, cin_i};
        ext    = '0;
        s_o    = '0;
        cout_o = '0;
        case (op_i)
            OP_ADD: begin
                ext    = ze + xe + ye + ce_ext;
                s_o    = ext[LANE_W-1:0];
                cout_o = ext[EW-1:LANE_W];
            end
            OP_SUB: begin
                // Top two bits hold floor(diff / 2^W) in two's complement; negate for borrow.
                ext    = ze - xe - ye - ce_ext;
                s_o    = ext[LANE_W-1:0];
                cout_o = ~ext[EW-1:LANE_W] + 2'd1;
            end
            OP_XOR: s_o = x_i ^ z_i;
            OP_AND: s_o = x_i & z_i;
            default: s_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_simd_pipe_acc.sv
// Two-stage SIMD/chained ALU with P accumulator feedback and clock enable.
// Pattern detect on P is built only when ALU_SIMD_PATTERN_DETECT_EN is defined.
module alu_simd_pipe_acc
    import alu_simd_pkg::*;
#(
    parameter int LANE_W = 18,
    parameter int LANES  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      in_valid,
    input  logic [1:0]                op,
    input  logic                      use_simd,
    input  logic                      acc_en,
    input  logic                      p_clr,
    input  logic [LANE_W*LANES-1:0]   X,
    input  logic [LANE_W*LANES-1:0]   Y,
    input  logic [LANE_W*LANES-1:0]   Z,
    input  logic                      CIN,
    input  logic [LANE_W*LANES-1:0]   pattern,
    output logic [LANE_W*LANES-1:0]   P,
    output logic                      out_valid,
    output logic [LANES-1:0]          cout,
    output logic                      pat_det
);
    localparam int N = LANE_W * LANES;

    logic [N-1:0]           x_q, y_q, z_q;
    logic [1:0]             op_q;
    logic                   cin_q, simd_q, acc_q, v1_q;
    logic [N-1:0]           p_q;
    logic [LANES-1:0]       cout_q;
    logic                   v2_q;
    logic [N-1:0]           z_eff, res_d;
    logic [LANES-1:0]       cout_d;
    logic [LANES-1:0][1:0]  lane_cin, lane_co;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            op_q   <= 2'b00;
            cin_q  <= 1'b0;
            simd_q <= 1'b0;
            acc_q  <= 1'b0;
            v1_q   <= 1'b0;
        end else if (ce) begin
            x_q    <= X;
            y_q    <= Y;
            z_q    <= Z;
            op_q   <= op;
            cin_q  <= CIN;
            simd_q <= use_simd;
            acc_q  <= acc_en;
            v1_q   <= in_valid;
        end
    end

    // Feedback reads P before this edge's update; p_clr zeroes it for a fresh accumulation.
    assign z_eff = acc_q ? (p_clr ? '0 : p_q) : z_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        if (i == 0) begin : g_first
            assign lane_cin[i] = {1'b0, cin_q};
        end else begin : g_rest
            assign lane_cin[i] = (simd_q == MODE_SIMD) ? {1'b0, cin_q} : lane_co[i-1];
        end

        if (i == LANES - 1) begin : g_top_cout
            assign cout_d[i] = |lane_co[i];
        end else begin : g_mid_cout
            assign cout_d[i] = (simd_q == MODE_SIMD) && (|lane_co[i]);
        end

        alu_simd_lane #(.LANE_W(LANE_W)) u_lane (
            .x_i    (x_q[i*LANE_W +: LANE_W]),
            .y_i    (y_q[i*LANE_W +: LANE_W]),
            .z_i    (z_eff[i*LANE_W +: LANE_W]),
            .op_i   (op_q),
            .cin_i  (lane_cin[i]),
            .s_o    (res_d[i*LANE_W +: LANE_W]),
            .cout_o (lane_co[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q    <= '0;
            cout_q <= '0;
            v2_q   <= 1'b0;
        end else if (ce) begin
            v2_q <= v1_q;
            if (v1_q) begin
                p_q    <= res_d;
                cout_q <= cout_d;
            end else if (p_clr) begin
                p_q    <= '0;
                cout_q <= '0;
            end
        end
    end

`ifdef ALU_SIMD_PATTERN_DETECT_EN
    logic pat_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_q <= 1'b0;
        end else if (ce && v1_q) begin
            pat_q <= (res_d == pattern);
        end
    end
    assign pat_det = pat_q;
`else
    logic unused_pattern;
    assign unused_pattern = ^pattern;
    assign pat_det        = 1'b0;
`endif

    assign P         = p_q;
    assign cout      = cout_q;
    assign out_valid = v2_q;

endmodule
